addmul_sched: RTL and testbench

Sequences one shared add/multiply execution unit between NREQ independent requesters. Each requester offers an operation (add or multiply) with two operands over a valid/ready handshake. The block arbitrates round-robin, runs the operation (add single-cycle, multiply multi-cycle), and returns a tagged result on a single valid/ready response channel. It sits between the requesting control FSMs and the arithmetic datapath.

---
 rtl/addmul_pkg.sv | 27 ++
 rtl/addmul_sched_rr_arbiter.sv | 54 +++++
 rtl/addmul_sched.sv | 129 ++++++++++++
 tb/tb_addmul_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addmul_pkg.sv
// Shared types, opcodes, state encoding and width helper for the add/multiply scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package addmul_pkg;

    // Opcode carried on req_op
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so that derived vectors never collapse to zero width
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addmul_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or above the pointer, wrapping.
// Latency: grant is combinational from req; pointer updates on the clock edge where adv is high.
// Backpressure: pointer only moves when the consumer strobes adv, so an unaccepted grant stays put.
module rr_arbiter
    import addmul_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic                     adv,
    output logic [NREQ-1:0]          gnt,
    output logic [clog2(NREQ)-1:0]   gnt_idx
);

    localparam int IDW = clog2(NREQ);
    localparam int SW  = IDW + 1;
    localparam logic [IDW-1:0] LAST  = IDW'(NREQ - 1);
    localparam logic [SW-1:0]  NREQ_W = SW'(NREQ);

    logic [IDW-1:0] ptr_q;
    logic [SW-1:0]  cand;
    logic           found;

    // Scan upward from the pointer, wrapping at NREQ, and take the first active request
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + SW'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
        gnt[gnt_idx] = found;
    end

    // Pointer moves to the slot just past the accepted winner; it holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/addmul_sched.sv
// Shares one add/multiply unit between NREQ requesters with round-robin grant and a tagged response.
// Latency: handshake in cycle T gives rsp_valid at T+2 for add, T+1+MUL_LAT for multiply.
// Backpressure: response is held until rsp_ready; no new grant is issued until it is taken.
module addmul_sched
    import addmul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [clog2(NREQ)-1:0]    rsp_id,
    output logic [2*WIDTH-1:0]        rsp_data,
    output logic                      busy
);

    localparam int IDW = clog2(NREQ);
    localparam int CW  = clog2(MUL_LAT + 1);
    localparam int DW  = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_ADD = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT);

    // Everything captured from the winning requester at the grant handshake
    typedef struct packed {
        logic             op;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } job_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    job_t            job_q;
    job_t            job_nxt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            req_hs;
    logic [DW-1:0]   result;

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .adv     (req_hs),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are only offered while idle, so at most one request is accepted per transaction
    assign req_ready = (state == ST_IDLE) ? gnt : '0;
    assign req_hs    = (state == ST_IDLE) && (|(req_valid & gnt));

    // Select the winner's opcode and operands for capture
    always_comb begin
        job_nxt    = '0;
        job_nxt.op = req_op[gnt_idx];
        job_nxt.id = gnt_idx;
        job_nxt.a  = req_a[gnt_idx*WIDTH +: WIDTH];
        job_nxt.b  = req_b[gnt_idx*WIDTH +: WIDTH];
    end

    // Full-width unsigned result; the multiply is given MUL_LAT cycles to settle before capture
    always_comb begin
        result = '0;
        if (job_q.op == OP_MUL) begin
            result = DW'(job_q.a) * DW'(job_q.b);
        end else begin
            result = DW'(job_q.a) + DW'(job_q.b);
        end
    end

    // Scheduler FSM: capture on grant, count down the execute cycles, hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            job_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_hs) begin
                        job_q <= job_nxt;
                        cnt   <= (job_nxt.op == OP_MUL) ? CNT_MUL : CNT_ADD;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == CNT_ADD) begin
                        rsp_data  <= result;
                        rsp_id    <= job_q.id;
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addmul_sched.sv
// Directed bench for the add/multiply scheduler with hand-computed expected values.
// Latency: checks exact response latency for add and multiply.
// Backpressure: holds rsp_ready low during a response and checks that everything freezes.
module tb_addmul_sched;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addmul_sched #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic op, input logic [7:0] a, input logic [7:0] b);
        req_op[id]          = op;
        req_a[id*8 +: 8]    = a;
        req_b[id*8 +: 8]    = b;
    endtask

    // Check the offered grant, then take the clock edge on which the handshake happens
    task automatic issue(input string tag, input logic [3:0] exp_gnt);
        #1;
        chk(tag, req_ready, exp_gnt);
        tick();
    endtask

    // Called just after the handshake edge; lat counts edges from the handshake cycle to rsp_valid
    task automatic wait_rsp(input string tag, input int exp_lat, input logic [1:0] exp_id,
                            input logic [15:0] exp_data);
        int lat;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            chk({tag, "_busy_exec"}, busy, 1);
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_id"}, rsp_id, exp_id);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_busy_resp"}, busy, 1);
    endtask

    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [15:0] rr_res [4] = '{16'h0011, 16'h0040, 16'h0033, 16'h0044};
    int rr_lat [4] = '{2, 4, 2, 2};
    int spurious;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ptr", dut.u_arb.ptr_q, 0);
        rst_n = 1'b1;
        tick();

        // Single add, boundary operands
        set_req(0, 1'b0, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        issue("add_gnt", 4'b0001);
        req_valid = '0;
        wait_rsp("add", 2, 2'd0, 16'h01FE);
        tick();
        chk("add_done_valid", rsp_valid, 0);
        chk("add_done_busy", busy, 0);
        chk("add_ptr", dut.u_arb.ptr_q, 1);

        // Multiply latency, full-width product
        set_req(2, 1'b1, 8'hFF, 8'hFF);
        req_valid = 4'b0100;
        issue("mul_gnt", 4'b0100);
        req_valid = '0;
        wait_rsp("mul", 1 + MUL_LAT, 2'd2, 16'hFE01);
        tick();
        chk("mul_done_busy", busy, 0);
        chk("mul_ptr", dut.u_arb.ptr_q, 3);

        // Grant the last requester so the pointer wraps to zero
        set_req(3, 1'b0, 8'h12, 8'h34);
        req_valid = 4'b1000;
        issue("wrap_gnt", 4'b1000);
        req_valid = '0;
        wait_rsp("wrap", 2, 2'd3, 16'h0046);
        tick();
        chk("wrap_ptr", dut.u_arb.ptr_q, 0);

        // Round robin with everyone requesting
        set_req(0, 1'b0, 8'h10, 8'h01);
        set_req(1, 1'b1, 8'h20, 8'h02);
        set_req(2, 1'b0, 8'h30, 8'h03);
        set_req(3, 1'b0, 8'h40, 8'h04);
        req_valid = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            issue("rr_gnt", 4'(1 << order[t]));
            wait_rsp("rr", rr_lat[order[t]], 2'(order[t]), rr_res[order[t]]);
            tick();
        end

        // Sparse requests from pointer 2: 3 then 1
        req_valid = 4'b1010;
        chk("rr2_ptr", dut.u_arb.ptr_q, 2);
        issue("rr2_gnt3", 4'b1000);
        wait_rsp("rr2_a", 2, 2'd3, 16'h0044);
        tick();
        issue("rr2_gnt1", 4'b0010);
        wait_rsp("rr2_b", 1 + MUL_LAT, 2'd1, 16'h0040);
        tick();
        req_valid = '0;

        // Backpressure: response frozen, other requests held off
        rsp_ready = 1'b0;
        set_req(0, 1'b0, 8'h05, 8'h07);
        req_valid = 4'b0001;
        issue("bp_gnt", 4'b0001);
        req_valid = 4'b1110;
        tick();
        chk("bp_valid_start", rsp_valid, 1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_data", rsp_data, 16'h000C);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_ptr", dut.u_arb.ptr_q, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tick();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_busy", busy, 0);
        #1;
        chk("bp_next_gnt", req_ready, 4'b0010);

        // Withdrawn request leaves no trace
        req_valid = '0;
        tick();
        chk("wd_ptr", dut.u_arb.ptr_q, 1);
        chk("wd_busy", busy, 0);

        // Reset in the second execute cycle of a multiply
        set_req(2, 1'b1, 8'hFF, 8'hFF);
        req_valid = 4'b0100;
        issue("rstm_gnt", 4'b0100);
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", rsp_valid, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_ptr", dut.u_arb.ptr_q, 0);
        chk("rstm_req_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) spurious++;
        end
        chk("rstm_no_rsp", spurious, 0);
        set_req(0, 1'b0, 8'h03, 8'h04);
        req_valid = 4'b1001;
        issue("rstm_first_gnt", 4'b0001);
        req_valid = '0;
        wait_rsp("rstm_add", 2, 2'd0, 16'h0007);
        tick();
        chk("rstm_ptr_after", dut.u_arb.ptr_q, 1);

        // Long idle with nothing requested
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_req_ready", req_ready, 0);
            chk("idle_busy", busy, 0);
        end
        chk("idle_ptr", dut.u_arb.ptr_q, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
